// File: rtl/slink_axi_pkg.sv
// Shared S-Link AXI packet definitions: default data IDs, word-count helpers and
// header layout, reused by the initiator/target packers and the response arbiter.
package slink_axi_pkg;

  localparam logic [7:0] B_PKT_DT_DEF = 8'h22;
  localparam logic [7:0] R_PKT_DT_DEF = 8'h24;

  // Header occupies bits [34:0]; payload data starts right above it.
  localparam int unsigned PKT_DT_LSB   = 0;
  localparam int unsigned PKT_WC_LSB   = 8;
  localparam int unsigned PKT_ID_LSB   = 24;
  localparam int unsigned PKT_RESP_LSB = 32;
  localparam int unsigned PKT_LAST_BIT = 34;
  localparam int unsigned PKT_DATA_LSB = 35;

  typedef enum logic {
    CH_B = 1'b0,
    CH_R = 1'b1
  } rsp_ch_e;

  // Field order matches the bit offsets above (MSB first).
  typedef struct packed {
    logic        last;
    logic [1:0]  resp;
    logic [7:0]  id;
    logic [15:0] wc;
    logic [7:0]  dt;
  } pkt_hdr_t;

  function automatic logic [15:0] wc_b();
    return 16'd3;
  endfunction

  function automatic logic [15:0] wc_r(input int unsigned data_width);
    return 16'(2 + data_width / 8);
  endfunction

endpackage

// File: rtl/slink_axi_rsp_arb_if.sv
// AXI B/R response channels plus the a2l packet stream seen by the response arbiter.
interface slink_axi_rsp_arb_if
  import slink_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64
) ();

  localparam int unsigned A2L_DATA_WIDTH = AXI_DATA_WIDTH + PKT_DATA_LSB;

  logic [7:0]                ini_bid;
  logic [1:0]                ini_bresp;
  logic                      ini_bvalid;
  logic                      ini_bready;

  logic [7:0]                ini_rid;
  logic [AXI_DATA_WIDTH-1:0] ini_rdata;
  logic [1:0]                ini_rresp;
  logic                      ini_rlast;
  logic                      ini_rvalid;
  logic                      ini_rready;

  logic                      a2l_valid;
  logic                      a2l_ready;
  logic [A2L_DATA_WIDTH-1:0] a2l_data;

  // Response source and packet sink side.
  modport master (
    output ini_bid, ini_bresp, ini_bvalid,
    input  ini_bready,
    output ini_rid, ini_rdata, ini_rresp, ini_rlast, ini_rvalid,
    input  ini_rready,
    input  a2l_valid, a2l_data,
    output a2l_ready
  );

  // Arbiter side.
  modport slave (
    input  ini_bid, ini_bresp, ini_bvalid,
    output ini_bready,
    input  ini_rid, ini_rdata, ini_rresp, ini_rlast, ini_rvalid,
    output ini_rready,
    output a2l_valid, a2l_data,
    input  a2l_ready
  );

endinterface

// File: rtl/slink_axi_rsp_arb.sv
// Round-robin scheduler of AXI B and R beats onto the single a2l packet stream,
// with read-burst locking and a starvation guard for pending B responses.
module slink_axi_rsp_arb
  import slink_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [7:0]  B_PKT_DT       = B_PKT_DT_DEF,
  parameter logic [7:0]  R_PKT_DT       = R_PKT_DT_DEF,
  parameter bit          R_BURST_LOCK   = 1'b1,
  parameter int unsigned B_STARVE_LIMIT = 16
) (
  input  logic                axi_clk,
  input  logic                axi_reset_n,
  input  logic                enable,
  slink_axi_rsp_arb_if.slave  bus,
  output logic                r_burst_active
);

  localparam int unsigned A2L_DATA_WIDTH = AXI_DATA_WIDTH + PKT_DATA_LSB;
  localparam logic [7:0]  STARVE_LIMIT   = 8'(B_STARVE_LIMIT);

  logic                      r_a2l_valid;
  logic [A2L_DATA_WIDTH-1:0] r_a2l_data;
  rsp_ch_e                   r_rr_last;
  logic                      r_lock;
  logic [7:0]                r_starve_cnt;

  logic                      w_space;
  logic                      w_accept_ok;
  logic                      w_force_b;
  logic                      w_grant_b;
  logic                      w_grant_r;
  pkt_hdr_t                  w_hdr;
  logic [AXI_DATA_WIDTH-1:0] w_data;

  // Reset gating keeps both readies low while axi_reset_n is asserted.
  assign w_space     = !r_a2l_valid || bus.a2l_ready;
  assign w_accept_ok = axi_reset_n && enable && w_space;
  assign w_force_b   = (r_starve_cnt >= STARVE_LIMIT) && bus.ini_bvalid;

  always_comb begin
    w_grant_b = 1'b0;
    w_grant_r = 1'b0;
    if (w_accept_ok) begin
      if (w_force_b) begin
        w_grant_b = 1'b1;
      end else if (r_lock) begin
        w_grant_r = bus.ini_rvalid;
      end else if (bus.ini_bvalid && bus.ini_rvalid) begin
        if (r_rr_last == CH_R) w_grant_b = 1'b1;
        else                   w_grant_r = 1'b1;
      end else begin
        w_grant_b = bus.ini_bvalid;
        w_grant_r = bus.ini_rvalid;
      end
    end
  end

  assign bus.ini_bready = w_grant_b;
  assign bus.ini_rready = w_grant_r;

  // Packet build for whichever channel is granted this cycle.
  always_comb begin
    w_hdr  = '0;
    w_data = '0;
    if (w_grant_b) begin
      w_hdr.dt   = B_PKT_DT;
      w_hdr.wc   = wc_b();
      w_hdr.id   = bus.ini_bid;
      w_hdr.resp = bus.ini_bresp;
    end else begin
      w_hdr.dt   = R_PKT_DT;
      w_hdr.wc   = wc_r(AXI_DATA_WIDTH);
      w_hdr.id   = bus.ini_rid;
      w_hdr.resp = bus.ini_rresp;
      w_hdr.last = bus.ini_rlast;
      w_data     = bus.ini_rdata;
    end
  end

  // Single output register; reloads on pop+accept in the same cycle.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_a2l_valid <= 1'b0;
      r_a2l_data  <= '0;
    end else if (w_grant_b || w_grant_r) begin
      r_a2l_valid <= 1'b1;
      r_a2l_data  <= {w_data, w_hdr};
    end else if (bus.a2l_ready) begin
      r_a2l_valid <= 1'b0;
    end
  end

  // Round-robin pointer and read-burst lock.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_rr_last <= CH_R;
      r_lock    <= 1'b0;
    end else if (w_grant_r) begin
      r_rr_last <= CH_R;
      if (bus.ini_rlast)     r_lock <= 1'b0;
      else if (R_BURST_LOCK) r_lock <= 1'b1;
    end else if (w_grant_b) begin
      r_rr_last <= CH_B;
    end
  end

  // Counts R beats taken while a B response is waiting; saturates at 255.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_b || !bus.ini_bvalid) begin
      r_starve_cnt <= '0;
    end else if (w_grant_r && (r_starve_cnt != 8'hFF)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  assign bus.a2l_valid  = r_a2l_valid;
  assign bus.a2l_data   = r_a2l_data;
  assign r_burst_active = r_lock;

endmodule

// File: tb/tb_slink_axi_rsp_arb.sv
// Directed bench for slink_axi_rsp_arb: expected packets queued as beats are offered,
// compared in order as the a2l stream hands them over.
module tb_slink_axi_rsp_arb;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = DW + 35;

  logic axi_clk     = 1'b0;
  logic axi_reset_n = 1'b1;
  logic enable      = 1'b0;
  logic r_burst_active;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] sb_q[$];

  slink_axi_rsp_arb_if #(.AXI_DATA_WIDTH(DW)) bus ();

  slink_axi_rsp_arb #(
    .AXI_DATA_WIDTH(DW),
    .B_PKT_DT      (8'h22),
    .R_PKT_DT      (8'h24),
    .R_BURST_LOCK  (1'b1),
    .B_STARVE_LIMIT(16)
  ) u_dut (
    .axi_clk       (axi_clk),
    .axi_reset_n   (axi_reset_n),
    .enable        (enable),
    .bus           (bus.slave),
    .r_burst_active(r_burst_active)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] pkt_b(input logic [7:0] id, input logic [1:0] resp);
    return {64'h0, 1'b0, resp, id, 16'd3, 8'h22};
  endfunction

  function automatic logic [AW-1:0] pkt_r(input logic [7:0] id, input logic [DW-1:0] data,
                                          input logic [1:0] resp, input logic last);
    return {data, last, resp, id, 16'd10, 8'h24};
  endfunction

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] id, input logic [1:0] resp);
    bus.ini_bvalid = v;
    bus.ini_bid    = id;
    bus.ini_bresp  = resp;
  endtask

  task automatic drive_r(input logic v, input logic [7:0] id, input logic [DW-1:0] data,
                         input logic [1:0] resp, input logic last);
    bus.ini_rvalid = v;
    bus.ini_rid    = id;
    bus.ini_rdata  = data;
    bus.ini_rresp  = resp;
    bus.ini_rlast  = last;
  endtask

  task automatic idle();
    drive_b(1'b0, 8'h00, 2'b00);
    drive_r(1'b0, 8'h00, 64'h0, 2'b00, 1'b0);
  endtask

  // Asserts reset with whatever inputs are applied, checks reset outputs, releases idle.
  task automatic do_reset();
    axi_reset_n = 1'b0;
    #1;
    chk1("rst_a2l_valid", bus.a2l_valid, 1'b0);
    chk("rst_a2l_data", bus.a2l_data, '0);
    chk1("rst_burst_active", r_burst_active, 1'b0);
    chk1("rst_bready", bus.ini_bready, 1'b0);
    chk1("rst_rready", bus.ini_rready, 1'b0);
    cyc();
    cyc();
    idle();
    axi_reset_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] exp_pkt;
    logic [34:0]   exp_hdr;
    logic [7:0]    nb;
    logic [7:0]    nr;
    int            since;
    int            rbeat;
    logic          exp_b;

    enable        = 1'b1;
    bus.a2l_ready = 1'b1;
    drive_b(1'b1, 8'hEE, 2'b11);
    drive_r(1'b1, 8'hEF, 64'hDEAD, 2'b11, 1'b1);

    // Scoreboard consumer: one expected packet per a2l handshake.
    fork
      forever begin
        @(negedge axi_clk);
        if (bus.a2l_valid === 1'b1 && bus.a2l_ready === 1'b1) begin
          chk1("sb_pending", sb_q.size() != 0, 1'b1);
          if (sb_q.size() != 0) begin
            exp_pkt = sb_q.pop_front();
            chk("sb_pkt", bus.a2l_data, exp_pkt);
          end
        end
      end
    join_none

    #2;
    do_reset();

    // B-only beat and its header layout.
    drive_b(1'b1, 8'h5A, 2'b10);
    #1;
    chk1("t1_bready", bus.ini_bready, 1'b1);
    chk1("t1_rready", bus.ini_rready, 1'b0);
    sb_q.push_back(pkt_b(8'h5A, 2'b10));
    cyc();
    idle();
    #1;
    chk1("t1_valid", bus.a2l_valid, 1'b1);
    exp_hdr = {1'b0, 2'b10, 8'h5A, 16'd3, 8'h22};
    chk("t1_hdr", AW'(bus.a2l_data[34:0]), AW'(exp_hdr));
    cyc();
    chk1("t1_valid_drop", bus.a2l_valid, 1'b0);

    // Round-robin from reset: B first, then alternate.
    do_reset();
    nb = 8'h10;
    nr = 8'h20;
    for (int i = 0; i < 6; i++) begin
      drive_b(1'b1, nb, 2'b00);
      drive_r(1'b1, nr, {32'hCAFE0000, 24'h0, nr}, 2'b01, 1'b1);
      #1;
      exp_b = (i % 2 == 0);
      chk1("t2_bready", bus.ini_bready, exp_b);
      chk1("t2_rready", bus.ini_rready, !exp_b);
      if (exp_b) begin
        sb_q.push_back(pkt_b(nb, 2'b00));
        nb++;
      end else begin
        sb_q.push_back(pkt_r(nr, {32'hCAFE0000, 24'h0, nr}, 2'b01, 1'b1));
        nr++;
      end
      cyc();
    end
    idle();
    cyc();
    cyc();

    // 4-beat locked burst; B arrives at beat 2 and waits until after rlast.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive_r(1'b1, 8'h33, 64'(k) * 64'h1111, 2'b00, k == 4);
      drive_b(k >= 2, 8'h44, 2'b01);
      #1;
      chk1("t3_rready", bus.ini_rready, 1'b1);
      chk1("t3_bready", bus.ini_bready, 1'b0);
      chk1("t3_lock", r_burst_active, k >= 2);
      sb_q.push_back(pkt_r(8'h33, 64'(k) * 64'h1111, 2'b00, k == 4));
      cyc();
    end
    drive_r(1'b0, 8'h00, 64'h0, 2'b00, 1'b0);
    #1;
    chk1("t3_b_after", bus.ini_bready, 1'b1);
    chk1("t3_lock_free", r_burst_active, 1'b0);
    sb_q.push_back(pkt_b(8'h44, 2'b01));
    cyc();
    idle();
    cyc();
    cyc();

    // 40-beat burst with B always pending: one forced B every 16 R beats.
    do_reset();
    drive_b(1'b1, 8'h50, 2'b00);
    #1;
    chk1("t4_b0", bus.ini_bready, 1'b1);
    sb_q.push_back(pkt_b(8'h50, 2'b00));
    cyc();
    nb    = 8'h51;
    since = 0;
    rbeat = 1;
    for (int s = 0; s < 48 && rbeat <= 40; s++) begin
      drive_b(1'b1, nb, 2'b00);
      drive_r(1'b1, 8'h60, 64'(rbeat), 2'b00, rbeat == 40);
      #1;
      exp_b = (since == 16);
      chk1("t4_bready", bus.ini_bready, exp_b);
      chk1("t4_rready", bus.ini_rready, !exp_b);
      if (exp_b) begin
        chk1("t4_lock_kept", r_burst_active, 1'b1);
        sb_q.push_back(pkt_b(nb, 2'b00));
        nb++;
        since = 0;
      end else begin
        sb_q.push_back(pkt_r(8'h60, 64'(rbeat), 2'b00, rbeat == 40));
        rbeat++;
        since++;
      end
      cyc();
    end
    chk_int("t4_rbeats", rbeat, 41);
    drive_r(1'b0, 8'h00, 64'h0, 2'b00, 1'b0);
    #1;
    chk1("t4_b_end", bus.ini_bready, 1'b1);
    chk1("t4_unlock", r_burst_active, 1'b0);
    sb_q.push_back(pkt_b(nb, 2'b00));
    cyc();
    idle();
    cyc();
    cyc();

    // Back-pressure: a2l_ready low for 5 cycles with both channels valid.
    do_reset();
    bus.a2l_ready = 1'b0;
    drive_b(1'b1, 8'h70, 2'b00);
    drive_r(1'b1, 8'h71, 64'h5555, 2'b10, 1'b1);
    #1;
    chk1("t5_first_b", bus.ini_bready, 1'b1);
    sb_q.push_back(pkt_b(8'h70, 2'b00));
    cyc();
    drive_b(1'b1, 8'h72, 2'b00);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk1("t5_bready_low", bus.ini_bready, 1'b0);
      chk1("t5_rready_low", bus.ini_rready, 1'b0);
      chk1("t5_valid_hold", bus.a2l_valid, 1'b1);
      chk("t5_data_hold", bus.a2l_data, pkt_b(8'h70, 2'b00));
      cyc();
    end
    bus.a2l_ready = 1'b1;
    #1;
    chk1("t5_r_resume", bus.ini_rready, 1'b1);
    chk1("t5_b_wait", bus.ini_bready, 1'b0);
    sb_q.push_back(pkt_r(8'h71, 64'h5555, 2'b10, 1'b1));
    cyc();
    drive_r(1'b0, 8'h00, 64'h0, 2'b00, 1'b0);
    #1;
    chk1("t5_reload_valid", bus.a2l_valid, 1'b1);
    chk1("t5_b_next", bus.ini_bready, 1'b1);
    sb_q.push_back(pkt_b(8'h72, 2'b00));
    cyc();
    idle();
    cyc();
    cyc();

    // Enable dropped mid-burst, then reset mid-burst.
    do_reset();
    drive_r(1'b1, 8'h80, 64'hA0, 2'b00, 1'b0);
    #1;
    chk1("t6_r1", bus.ini_rready, 1'b1);
    sb_q.push_back(pkt_r(8'h80, 64'hA0, 2'b00, 1'b0));
    cyc();
    enable = 1'b0;
    drive_r(1'b1, 8'h80, 64'hA1, 2'b00, 1'b0);
    drive_b(1'b1, 8'h81, 2'b00);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("t6_dis_rready", bus.ini_rready, 1'b0);
      chk1("t6_dis_bready", bus.ini_bready, 1'b0);
      chk1("t6_dis_lock", r_burst_active, 1'b1);
      chk1("t6_drain", bus.a2l_valid, c == 0);
      cyc();
    end
    enable = 1'b1;
    #1;
    chk1("t6_resume_r", bus.ini_rready, 1'b1);
    chk1("t6_resume_b", bus.ini_bready, 1'b0);
    sb_q.push_back(pkt_r(8'h80, 64'hA1, 2'b00, 1'b0));
    cyc();
    #6;
    do_reset();
    drive_b(1'b1, 8'h90, 2'b01);
    drive_r(1'b1, 8'h91, 64'hB0, 2'b00, 1'b0);
    #1;
    chk1("t6_post_bready", bus.ini_bready, 1'b1);
    chk1("t6_post_rready", bus.ini_rready, 1'b0);
    chk1("t6_post_lock", r_burst_active, 1'b0);
    sb_q.push_back(pkt_b(8'h90, 2'b01));
    cyc();
    idle();
    cyc();
    cyc();
    cyc();

    chk_int("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
